// File: rtl/alu_pkg.sv
// Shared definitions for the sign-magnitude ALU: op codes, saturation constant
// and the buffered result entry.
package alu_pkg;

    localparam int ALU_DATA_W = 32;

    localparam logic [2:0] ALU_SUB   = 3'b111;
    localparam logic [2:0] ALU_ABSD  = 3'b101;
    localparam logic [2:0] ALU_PASSA = 3'b100;

    localparam logic [ALU_DATA_W-1:0] SM_NEG_MAX = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] sm;
        logic [2:0]            op;
        logic                  zero;
        logic                  ovf;
    } res_entry_t;

endpackage

// File: rtl/tc_to_sm.sv
// Combinational two's-complement to sign-magnitude conversion with zero and
// saturation flags.
module tc_to_sm #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] tc_i,
    output logic [DATA_W-1:0] sm_o,
    output logic              zero_o,
    output logic              ovf_o
);

    logic signed [DATA_W-1:0] tc_s;
    logic signed [DATA_W-1:0] neg_s;

    assign tc_s  = tc_i;
    assign neg_s = -tc_s;

    always_comb begin
        zero_o = (tc_i == '0);
        // The most negative value has no positive counterpart; it saturates to -max.
        ovf_o  = tc_i[DATA_W-1] && (tc_i[DATA_W-2:0] == '0);
        if (!tc_i[DATA_W-1]) begin
            sm_o = tc_i;
        end else if (ovf_o) begin
            sm_o = '1;
        end else begin
            sm_o = {1'b1, neg_s[DATA_W-2:0]};
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: converts results to sign-magnitude, buffers them in a
// 2-entry skid FIFO and keeps saturating accept/overflow statistics.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [2:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sm,
    output logic [2:0]        out_op,
    output logic              out_zero,
    output logic              out_ovf,
    input  logic              flush,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_total,
    output logic [CNT_W-1:0]  cnt_ovf
);

    logic [DATA_W-1:0] conv_sm;
    logic              conv_zero;
    logic              conv_ovf;
    res_entry_t        conv_e;
    res_entry_t        head_e;
    res_entry_t        mem_q [2];

    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  cnt_total_q, cnt_total_d;
    logic [CNT_W-1:0]  cnt_ovf_q, cnt_ovf_d;
    logic              push;
    logic              pop;

    tc_to_sm #(.DATA_W(DATA_W)) u_tc_to_sm (
        .tc_i   (in_result),
        .sm_o   (conv_sm),
        .zero_o (conv_zero),
        .ovf_o  (conv_ovf)
    );

    always_comb begin
        conv_e.sm   = conv_sm;
        conv_e.op   = in_op;
        conv_e.zero = conv_zero;
        conv_e.ovf  = conv_ovf;
    end

    // A flush swallows any push on the same edge, so it is neither stored nor counted.
    assign push = in_valid && in_ready_q && !flush;
    assign pop  = (count_q != 2'd0) && out_ready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
        in_ready_d = (count_d != 2'd2);
    end

    always_comb begin
        cnt_total_d = cnt_total_q;
        cnt_ovf_d   = cnt_ovf_q;
        if (clr_cnt) begin
            cnt_total_d = '0;
            cnt_ovf_d   = '0;
        end else if (push) begin
            if (cnt_total_q != '1)           cnt_total_d = cnt_total_q + CNT_W'(1);
            if (conv_ovf && cnt_ovf_q != '1) cnt_ovf_d   = cnt_ovf_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt_total_q <= '0;
            cnt_ovf_q   <= '0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_ready_q  <= in_ready_d;
            cnt_total_q <= cnt_total_d;
            cnt_ovf_q   <= cnt_ovf_d;
        end
    end

    // Storage carries no reset; outputs are masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= conv_e;
    end

    assign head_e    = mem_q[rd_ptr_q];
    assign out_valid = (count_q != 2'd0);
    assign out_sm    = out_valid ? head_e.sm   : '0;
    assign out_op    = out_valid ? head_e.op   : 3'd0;
    assign out_zero  = out_valid ? head_e.zero : 1'b0;
    assign out_ovf   = out_valid ? head_e.ovf  : 1'b0;
    assign in_ready  = in_ready_q;
    assign cnt_total = cnt_total_q;
    assign cnt_ovf   = cnt_ovf_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_alu_result_stage;

    typedef struct packed {
        logic [31:0] sm;
        logic [2:0]  op;
        logic        zero;
        logic        ovf;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sm;
    logic [2:0]  out_op;
    logic        out_zero;
    logic        out_ovf;
    logic        flush;
    logic        clr_cnt;
    logic [15:0] cnt_total;
    logic [15:0] cnt_ovf;

    ent_t q[$];
    int   m_tot;
    int   m_ovf;
    int   n_tests;
    int   n_fail;

    always #5 clk = ~clk;

    alu_result_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sm    (out_sm),
        .out_op    (out_op),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .flush     (flush),
        .clr_cnt   (clr_cnt),
        .cnt_total (cnt_total),
        .cnt_ovf   (cnt_ovf)
    );

    function automatic ent_t conv(logic [31:0] r, logic [2:0] op);
        ent_t   e;
        longint v;
        v      = longint'($signed(r));
        e.op   = op;
        e.zero = (r == 32'd0);
        e.ovf  = (r == 32'h8000_0000);
        if (e.ovf)      e.sm = 32'hFFFF_FFFF;
        else if (v < 0) e.sm = 32'h8000_0000 | 32'(-v);
        else            e.sm = r;
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        m_tot = 0;
        m_ovf = 0;
    endtask

    // One clock: decide transfers from pre-edge state, advance model, sample 1 time unit later.
    task automatic tick();
        bit   push_m;
        bit   pop_m;
        ent_t e;
        push_m = in_valid && (q.size() < 2) && !flush;
        pop_m  = (q.size() != 0) && out_ready;
        e      = conv(in_result, in_op);
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (pop_m)  void'(q.pop_front());
            if (push_m) q.push_back(e);
        end
        if (clr_cnt) begin
            m_tot = 0;
            m_ovf = 0;
        end else if (push_m) begin
            if (m_tot < 65535) m_tot++;
            if (e.ovf && m_ovf < 65535) m_ovf++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_op = '0;
        out_ready = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
        model_reset();
        #12;
        n_tests++;
        if ({in_ready, out_valid, out_sm, out_op, out_zero, out_ovf, cnt_total, cnt_ovf} !==
            {1'b1, 1'b0, 32'h0, 3'h0, 1'b0, 1'b0, 16'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b sm=%h op=%0d z=%b o=%b tot=%0d ovf=%0d, need rdy=1 vld=0 all else 0",
                     in_ready, out_valid, out_sm, out_op, out_zero, out_ovf, cnt_total, cnt_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        in_valid = 1'b1; in_result = 32'hFFFF_FFFB; in_op = 3'b111; out_ready = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_no_comb_path: out_valid got %b need 0", out_valid);
        end
        tick();
        in_valid = 1'b0;
        n_tests++;
        if ({out_valid, out_sm, out_op, out_zero, out_ovf, cnt_total} !==
            {1'b1, 32'h8000_0005, 3'b111, 1'b0, 1'b0, 16'd1}) begin
            n_fail++;
            $display("FAIL basic_neg5: got vld=%b sm=%h op=%0d z=%b o=%b tot=%0d, need 1 80000005 7 0 0 1",
                     out_valid, out_sm, out_op, out_zero, out_ovf, cnt_total);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pop_empty: out_valid got %b need 0", out_valid);
        end
    endtask

    task automatic test_ovf_zero();
        in_valid = 1'b1; in_result = 32'h8000_0000; in_op = 3'b101;
        tick();
        n_tests++;
        if ({out_valid, out_sm, out_ovf, out_zero, cnt_ovf} !== {1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 16'd1}) begin
            n_fail++;
            $display("FAIL ovf_min: got vld=%b sm=%h o=%b z=%b cnt_ovf=%0d, need 1 ffffffff 1 0 1",
                     out_valid, out_sm, out_ovf, out_zero, cnt_ovf);
        end
        in_result = 32'd0; in_op = 3'b100; out_ready = 1'b1;
        tick();
        n_tests++;
        if ({out_valid, out_sm, out_zero, out_ovf, out_op} !== {1'b1, 32'h0, 1'b1, 1'b0, 3'b100}) begin
            n_fail++;
            $display("FAIL zero_result: got vld=%b sm=%h z=%b o=%b op=%0d, need 1 0 1 0 4",
                     out_valid, out_sm, out_zero, out_ovf, out_op);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_full();
        int base;
        base = m_tot;
        out_ready = 1'b0; in_valid = 1'b1; in_op = 3'b100;
        in_result = 32'd5;
        tick();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_ready_one: in_ready got %b need 1", in_ready);
        end
        in_result = 32'hFFFF_FFFF;
        tick();
        in_result = 32'h7FFF_FFFF;
        tick();
        tick();
        n_tests++;
        if ({in_ready, out_valid, out_sm, cnt_total} !== {1'b0, 1'b1, 32'd5, 16'(base + 2)}) begin
            n_fail++;
            $display("FAIL full_hold: got rdy=%b vld=%b sm=%h tot=%0d, need 0 1 00000005 %0d",
                     in_ready, out_valid, out_sm, cnt_total, base + 2);
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if ({in_ready, out_valid, out_sm} !== {1'b1, 1'b1, 32'h8000_0001}) begin
            n_fail++;
            $display("FAIL full_second: got rdy=%b vld=%b sm=%h, need 1 1 80000001", in_ready, out_valid, out_sm);
        end
        tick();
        n_tests++;
        if ({out_valid, out_sm, cnt_total} !== {1'b1, 32'h7FFF_FFFF, 16'(base + 3)}) begin
            n_fail++;
            $display("FAIL full_third: got vld=%b sm=%h tot=%0d, need 1 7fffffff %0d",
                     out_valid, out_sm, cnt_total, base + 3);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drain: out_valid got %b need 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        logic [2:0]  op;
        ent_t        e;
        in_valid = 1'b1; out_ready = 1'b0;
        in_result = $urandom; in_op = 3'($urandom);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            v = $urandom;
            op = 3'($urandom);
            in_result = v; in_op = op;
            tick();
            e = conv(v, op);
            n_tests++;
            if ({out_valid, in_ready, out_sm, out_op, out_zero, out_ovf} !==
                {1'b1, 1'b1, e.sm, e.op, e.zero, e.ovf}) begin
                n_fail++;
                $display("FAIL b2b_%0d: got vld=%b rdy=%b sm=%h op=%0d, need 1 1 %h %0d",
                         i, out_valid, in_ready, out_sm, out_op, e.sm, e.op);
            end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        int base;
        base = m_tot;
        out_ready = 1'b0; in_valid = 1'b1; in_result = 32'd123; in_op = 3'b111;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++;
        if ({out_valid, in_ready, cnt_total} !== {1'b0, 1'b1, 16'(base + 2)}) begin
            n_fail++;
            $display("FAIL flush_full: got vld=%b rdy=%b tot=%0d, need 0 1 %0d", out_valid, in_ready, cnt_total, base + 2);
        end
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_tests++;
        if ({out_valid, in_ready, cnt_total} !== {1'b0, 1'b1, 16'(base + 3)}) begin
            n_fail++;
            $display("FAIL flush_drop_push: got vld=%b rdy=%b tot=%0d, need 0 1 %0d", out_valid, in_ready, cnt_total, base + 3);
        end
    endtask

    task automatic test_saturation();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1; in_result = 32'h8000_0000; in_op = 3'b101;
        for (int i = 0; i < 65534; i++) tick();
        n_tests++;
        if ({cnt_total, cnt_ovf} !== {16'hFFFE, 16'hFFFE}) begin
            n_fail++;
            $display("FAIL sat_preload: got tot=%h ovf=%h, need fffe fffe", cnt_total, cnt_ovf);
        end
        tick();
        tick();
        n_tests++;
        if ({cnt_total, cnt_ovf} !== {16'hFFFF, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL sat_hold: got tot=%h ovf=%h, need ffff ffff", cnt_total, cnt_ovf);
        end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        n_tests++;
        if ({cnt_total, cnt_ovf} !== {16'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL clr_beats_push: got tot=%h ovf=%h, need 0 0", cnt_total, cnt_ovf);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        ent_t h;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 3) != 0;
            out_ready = ($urandom % 2) != 0;
            flush     = ($urandom % 25) == 0;
            clr_cnt   = ($urandom % 40) == 0;
            in_op     = 3'($urandom);
            case ($urandom % 6)
                0:       in_result = 32'd0;
                1:       in_result = 32'h8000_0000;
                2:       in_result = 32'h7FFF_FFFF;
                3:       in_result = 32'hFFFF_FFFF;
                default: in_result = $urandom;
            endcase
            tick();
            h = (q.size() != 0) ? q[0] : '0;
            n_tests++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2) ||
                cnt_total !== 16'(m_tot) || cnt_ovf !== 16'(m_ovf) ||
                (q.size() != 0 && {out_sm, out_op, out_zero, out_ovf} !== h)) begin
                n_fail++;
                $display("FAIL random_%0d: got vld=%b rdy=%b sm=%h op=%0d z=%b o=%b tot=%0d ovf=%0d, need vld=%b rdy=%b sm=%h op=%0d z=%b o=%b tot=%0d ovf=%0d",
                         i, out_valid, in_ready, out_sm, out_op, out_zero, out_ovf, cnt_total, cnt_ovf,
                         q.size() != 0, q.size() < 2, h.sm, h.op, h.zero, h.ovf, m_tot, m_ovf);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_result = 32'hFFFF_FF00; in_op = 3'b111;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({in_ready, out_valid, out_sm, out_op, out_zero, out_ovf, cnt_total, cnt_ovf} !==
            {1'b1, 1'b0, 32'h0, 3'h0, 1'b0, 1'b0, 16'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_mid: got rdy=%b vld=%b sm=%h op=%0d tot=%0d ovf=%0d, need rdy=1 vld=0 all else 0",
                     in_ready, out_valid, out_sm, out_op, cnt_total, cnt_ovf);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_release: got vld=%b rdy=%b, need 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic();
        test_ovf_zero();
        test_full();
        test_back_to_back();
        test_flush();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
